// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared parameters and FSM encoding for the grid drain engine
package grid_pkg;

    localparam int COMPLEX               = 2;
    localparam int PRECISION             = 32;
    localparam int BRAM_PARALLELISM_BITS = 4;
    localparam int BRAM_DEPTH_BITS       = 10;
    localparam int BRAM_WIDTH            = (2 ** BRAM_PARALLELISM_BITS) * PRECISION * COMPLEX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_e;

endpackage

// File: rtl/grid_drain_if.sv
// rtl/grid_drain_if.sv - BRAM port and output stream bundle between the drain engine and its environment
interface grid_drain_if #(
    parameter int DW = grid_pkg::BRAM_WIDTH,
    parameter int AW = grid_pkg::BRAM_DEPTH_BITS + grid_pkg::BRAM_PARALLELISM_BITS
) ();

    logic          bram_re;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_rdata;
    logic          bram_we;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;

    modport master (
        output bram_re, bram_raddr, bram_we, bram_waddr, bram_wdata,
        output out_data, out_valid, out_last,
        input  bram_rdata, out_ready
    );

    modport slave (
        input  bram_re, bram_raddr, bram_we, bram_waddr, bram_wdata,
        input  out_data, out_valid, out_last,
        output bram_rdata, out_ready
    );

endinterface

// File: rtl/grid_skid_fifo.sv
// rtl/grid_skid_fifo.sv - 2-entry fall-through FIFO carrying a data word plus a last flag
module grid_skid_fifo #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_ready,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_last,
    output logic [1:0]    o_count
);
    import grid_pkg::*;

    logic [DW:0] r_mem [2];
    logic        r_wr;
    logic        r_rd;
    logic [1:0]  r_count;
    logic        w_empty;
    logic        w_pop;
    logic        w_store;
    logic [DW:0] w_head;

    // An arriving word bypasses storage when the FIFO is empty, so output follows the BRAM by zero cycles.
    assign w_empty = (r_count == 2'd0);
    assign o_valid = !w_empty || i_push;
    assign w_pop   = o_valid && i_ready;
    assign w_store = i_push && !(w_empty && w_pop);
    assign w_head  = !w_empty ? r_mem[r_rd] : (i_push ? {i_last, i_data} : '0);
    assign o_data  = w_head[DW-1:0];
    assign o_last  = w_head[DW];
    assign o_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
            if (w_store) begin
                r_mem[r_wr] <= {i_last, i_data};
                r_wr        <= ~r_wr;
            end
            if (w_pop && !w_empty) begin
                r_rd <= ~r_rd;
            end
        end
    end

endmodule

// File: rtl/grid_drain.sv
// rtl/grid_drain.sv - scans the grid BRAM in address order, streams each word out and optionally zeroes it
module grid_drain #(
    parameter int COMPLEX               = grid_pkg::COMPLEX,
    parameter int PRECISION             = grid_pkg::PRECISION,
    parameter int BRAM_PARALLELISM_BITS = grid_pkg::BRAM_PARALLELISM_BITS,
    parameter int BRAM_DEPTH_BITS       = grid_pkg::BRAM_DEPTH_BITS,
    parameter int CLEAR_ON_READ         = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         busy,
    output logic         done,
    grid_drain_if.master bus
);
    import grid_pkg::*;

    localparam int BRAM_WIDTH = (2 ** BRAM_PARALLELISM_BITS) * PRECISION * COMPLEX;
    localparam int AW         = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS;

    drain_state_e               r_state;
    drain_state_e               w_next;
    logic [BRAM_DEPTH_BITS-1:0] r_cnt;
    logic                       r_inflight;
    logic                       r_inflight_last;
    logic [AW-1:0]              r_waddr;
    logic [AW-1:0]              w_raddr;
    logic [1:0]                 w_fifo_count;
    logic                       w_issue;
    logic                       w_term;
    logic                       w_drained;
    logic                       w_credit_ok;
    logic [BRAM_WIDTH-1:0]      w_out_data;
    logic                       w_out_valid;
    logic                       w_out_last;

    // Stored words plus the one read in flight may never exceed the two FIFO slots.
    assign w_term      = &r_cnt;
    assign w_drained   = (w_fifo_count == 2'd0) && !r_inflight;
    assign w_credit_ok = ({1'b0, w_fifo_count} + {2'b00, r_inflight}) < 3'd2;
    assign w_raddr     = {r_cnt, {BRAM_PARALLELISM_BITS{1'b0}}};

    always_comb begin
        w_next  = r_state;
        busy    = 1'b0;
        done    = 1'b0;
        w_issue = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_READ;
            end
            ST_READ: begin
                busy = 1'b1;
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    if (w_term) w_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_drained) begin
                    done   = 1'b1;
                    w_next = ST_IDLE;
                end else begin
                    busy = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_waddr         <= '0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_cnt <= '0;
            end else if (w_issue) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_term;
            if (w_issue) begin
                r_waddr <= w_raddr;
            end
        end
    end

    grid_skid_fifo #(
        .DW (BRAM_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (r_inflight),
        .i_data  (bus.bram_rdata),
        .i_last  (r_inflight_last),
        .i_ready (bus.out_ready),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .o_last  (w_out_last),
        .o_count (w_fifo_count)
    );

    // The clear lands on the cycle the read data returns, never before the read of that word.
    assign bus.bram_re    = w_issue;
    assign bus.bram_raddr = w_raddr;
    assign bus.bram_we    = (CLEAR_ON_READ != 0) && r_inflight;
    assign bus.bram_waddr = r_waddr;
    assign bus.bram_wdata = '0;
    assign bus.out_data   = w_out_data;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_last   = w_out_last;

endmodule

// File: tb/tb_grid_drain.sv
// tb/tb_grid_drain.sv - directed bench for grid_drain with 4-word BRAM models, clearing and non-clearing instances
module tb_grid_drain;

    localparam int PB = 4;
    localparam int DB = 2;
    localparam int W  = 1024;
    localparam int AW = DB + PB;
    localparam int N  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic load_req = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    logic [W-1:0]  mem_a [N];
    logic [W-1:0]  mem_b [N];
    logic [W-1:0]  q_a [$];
    logic          ql_a [$];
    logic [W-1:0]  q_b [$];
    logic [AW-1:0] we_q [$];
    int            re_cnt = 0;
    int            done_cnt = 0;
    logic          b_we_seen = 1'b0;

    always #5 clk = ~clk;

    grid_drain_if #(.DW(W), .AW(AW)) bus_a ();
    grid_drain_if #(.DW(W), .AW(AW)) bus_b ();

    assign bus_a.out_ready = out_ready;
    assign bus_b.out_ready = out_ready;

    grid_drain #(
        .COMPLEX(2), .PRECISION(32), .BRAM_PARALLELISM_BITS(PB), .BRAM_DEPTH_BITS(DB), .CLEAR_ON_READ(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a), .done(done_a), .bus(bus_a)
    );

    grid_drain #(
        .COMPLEX(2), .PRECISION(32), .BRAM_PARALLELISM_BITS(PB), .BRAM_DEPTH_BITS(DB), .CLEAR_ON_READ(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b), .bus(bus_b)
    );

    function automatic logic [W-1:0] word(input int k);
        logic [63:0] s;
        s = 64'(k + 1);
        return {16{s}};
    endfunction

    always @(posedge clk) begin
        if (bus_a.bram_re) bus_a.bram_rdata <= mem_a[bus_a.bram_raddr[AW-1:PB]];
        if (bus_b.bram_re) bus_b.bram_rdata <= mem_b[bus_b.bram_raddr[AW-1:PB]];
        if (load_req) begin
            for (int k = 0; k < N; k++) begin
                mem_a[k] <= word(k);
                mem_b[k] <= word(k);
            end
        end else begin
            if (bus_a.bram_we) mem_a[bus_a.bram_waddr[AW-1:PB]] <= bus_a.bram_wdata;
            if (bus_b.bram_we) mem_b[bus_b.bram_waddr[AW-1:PB]] <= bus_b.bram_wdata;
        end
    end

    always @(negedge clk) begin
        if (bus_a.out_valid && out_ready) begin
            q_a.push_back(bus_a.out_data);
            ql_a.push_back(bus_a.out_last);
        end
        if (bus_b.out_valid && out_ready) q_b.push_back(bus_b.out_data);
        if (bus_a.bram_we) we_q.push_back(bus_a.bram_waddr);
        if (bus_b.bram_we) b_we_seen = 1'b1;
        if (bus_a.bram_re) re_cnt++;
        if (done_a) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    task automatic chk_words_a(input string tag, input bit zeros);
        chk({tag, "_count"}, W'(q_a.size()), W'(N));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_w%0d", tag, i), (i < q_a.size()) ? q_a[i] : W'(0), zeros ? W'(0) : word(i));
        end
    endtask

    task automatic wait_done(input string tag);
        int d0;
        int i;
        d0 = done_cnt;
        for (i = 0; i < 300 && done_cnt == d0; i++) tick();
        chk(tag, W'(done_cnt != d0), W'(1));
    endtask

    task automatic reload();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_flags"}, W'({busy_a, done_a, bus_a.out_valid, bus_a.out_last, bus_a.bram_re, bus_a.bram_we}), W'(0));
        chk({tag, "_raddr"}, W'(bus_a.bram_raddr), W'(0));
        chk({tag, "_waddr"}, W'(bus_a.bram_waddr), W'(0));
        chk({tag, "_data"}, bus_a.out_data, W'(0));
        chk({tag, "_wdata"}, bus_a.bram_wdata, W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ef;
        int d0;

        rst = 1'b0;
        reload();
        tick();
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Cycle-accurate drain with out_ready held high.
        q_a.delete(); ql_a.delete(); q_b.delete(); we_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            ef = {c >= 1 && c <= 5, c == 6, c >= 2 && c <= 5, c == 5, c >= 1 && c <= 4, c >= 2 && c <= 5};
            chk($sformatf("t1_flags_c%0d", c),
                W'({busy_a, done_a, bus_a.out_valid, bus_a.out_last, bus_a.bram_re, bus_a.bram_we}), W'(ef));
            if (c >= 1 && c <= 4) chk($sformatf("t1_raddr_c%0d", c), W'(bus_a.bram_raddr), W'((c - 1) * 16));
            if (c >= 2 && c <= 5) begin
                chk($sformatf("t1_data_c%0d", c), bus_a.out_data, word(c - 2));
                chk($sformatf("t1_waddr_c%0d", c), W'(bus_a.bram_waddr), W'((c - 2) * 16));
            end
            tick();
        end
        chk_words_a("t1_words", 1'b0);
        chk("t1_last", W'({ql_a.size() > 3 ? ql_a[3] : 1'b0, ql_a.size() > 2 ? ql_a[2] : 1'b1,
                           ql_a.size() > 1 ? ql_a[1] : 1'b1, ql_a.size() > 0 ? ql_a[0] : 1'b1}), W'(4'b1000));
        chk("t2_we_count", W'(we_q.size()), W'(4));
        for (int i = 0; i < 4; i++) chk($sformatf("t2_we_addr%0d", i), W'(i < we_q.size() ? we_q[i] : 6'h3f), W'(i * 16));

        // Second drain: the clearing instance returns zeros, the non-clearing one repeats its data.
        q_a.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t2_done");
        chk_words_a("t2_zero", 1'b1);
        chk("t6_b_count", W'(q_b.size()), W'(2 * N));
        for (int i = 0; i < 2 * N; i++) chk($sformatf("t6_b_w%0d", i), i < q_b.size() ? q_b[i] : W'(0), word(i % N));

        // Back-pressure: ready low for ten cycles after start.
        reload();
        q_a.delete();
        re_cnt = 0;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (c >= 2) chk($sformatf("t3_hold_c%0d", c), bus_a.out_data, word(0));
            tick();
        end
        chk("t3_re_count", W'(re_cnt), W'(2));
        chk("t3_valid", W'(bus_a.out_valid), W'(1));
        out_ready = 1'b1;
        wait_done("t3_done");
        chk_words_a("t3_words", 1'b0);

        // Random ready with a start pulse landing mid-drain.
        reload();
        q_a.delete();
        d0 = done_cnt;
        start = 1'b1;
        tick();
        for (int i = 0; i < 200; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("t4_busy", W'(busy_a), W'(0));
        chk("t4_done_count", W'(done_cnt - d0), W'(1));
        chk_words_a("t4_words", 1'b0);

        // Reset asserted at cycle 3 of a drain, then a fresh drain.
        reload();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_reset_outputs("t5_inreset");
        reload();
        tick();
        rst = 1'b1;
        tick();
        q_a.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_first_re", W'({bus_a.bram_re, bus_a.bram_raddr}), W'({1'b1, 6'd0}));
        wait_done("t5_done");
        chk_words_a("t5_words", 1'b0);

        chk("t6_b_no_we", W'(b_we_seen), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/grid_drain.md
# grid_drain

Read-out engine for the gridding accumulator memory. After an accumulation pass, `grid_drain` scans every word of the grid BRAM in ascending address order and streams each 16-sample word out over a valid/ready interface. It optionally writes zeros back to each word it has read, so the grid is clean for the next pass. It sits on the BRAM's second port, opposite the accumulate/write-back path, and is the only consumer of finished grid data.

## Interface
Parameters:
- `COMPLEX`, 2: components per sample.
- `PRECISION`, 32: bits per component.
- `BRAM_PARALLELISM_BITS`, 4: log2 of samples per BRAM word.
- `BRAM_DEPTH_BITS`, 10: log2 of BRAM words.
- `CLEAR_ON_READ`, 1: when 1, zero each word after reading it.
- `BRAM_WIDTH` (derived): 2^`BRAM_PARALLELISM_BITS` * `PRECISION` * `COMPLEX`, which is 1024 bits at defaults.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset; asynchronous, active-low (0 = reset).
- `start`, in, 1: begin a drain; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `start` until `done`.
- `done`, out, 1: one-cycle pulse at the end of a drain.
- `bram_re`, out, 1: BRAM read enable.
- `bram_raddr`, out, `BRAM_DEPTH_BITS`+`BRAM_PARALLELISM_BITS`: read address in sample units; low `BRAM_PARALLELISM_BITS` are always 0 (aligned).
- `bram_rdata`, in, `BRAM_WIDTH`: read data, valid exactly 1 cycle after `bram_re`.
- `bram_we`, out, 1: write enable for the clear.
- `bram_waddr`, out, same width as `bram_raddr`: clear address, aligned.
- `bram_wdata`, out, `BRAM_WIDTH`: constant 0.
- `out_data`, out, `BRAM_WIDTH`: grid word, with sample 0 in the LSBs.
- `out_valid`, out, 1: `out_data` is valid.
- `out_ready`, in, 1: the consumer accepts the word.
- `out_last`, out, 1: qualifies the final word (address 2^`BRAM_DEPTH_BITS`-1).

## Operation
- FSM states are IDLE, READ and FLUSH.
- **IDLE:** if `start`=1, the word counter is set to 0 and the FSM moves to READ; `busy` goes to 1 on the next cycle.
- **READ:**
  - A read of counter address k is issued (`bram_re`=1, `bram_raddr`=k<<`BRAM_PARALLELISM_BITS`) only when skid entries plus reads in flight total less than 2.
  - The counter then increments.
  - After issuing the read of the last word, the FSM moves to FLUSH.
- **Data return:** one cycle after the read of word k, `bram_rdata` is pushed into the 2-entry skid FIFO.
- **Clear:** in the same cycle as the push, if `CLEAR_ON_READ`=1, `bram_we`=1 and `bram_waddr`=k<<`BRAM_PARALLELISM_BITS`.
- **FLUSH:** when the FIFO is empty and nothing is in flight, `done`=1 for one cycle, `busy` goes to 0, and the FSM returns to IDLE.
- **Output stream:** `out_valid` equals FIFO not-empty. `out_last` is carried with the last word through the FIFO. A word pops on `out_valid`&`out_ready`.
- **Address arithmetic:** the counter is `BRAM_DEPTH_BITS` wide. Completion is detected by a terminal-count flag, not by wrap to 0.
- **`start` while busy:** ignored; no queued restart.
- **`out_ready` held low:** at most 2 reads are issued; the FSM then stalls with no further `bram_re` and no lost data.
- **Reset mid-drain:** the FSM returns to IDLE, the FIFO empties, and the outputs take reset values. Memory is left partially cleared; this is acceptable, and the host re-runs the accumulate pass.
- **Reset values:** `busy`, `done`, `bram_re`, `bram_we`, `out_valid` and `out_last` are 0. `bram_raddr`, `bram_waddr` and `out_data` are 0. `bram_wdata` is always 0.

## Timing
- `start` is sampled at cycle 0.
- First `bram_re` at cycle 1.
- First `out_valid` at cycle 2, so start-to-first-data latency is 2 cycles.
- With `out_ready` held at 1: one word per cycle, and N=2^`BRAM_DEPTH_BITS` words are accepted on cycles 2..N+1.
- `done` at cycle N+2.
- A clear write for word k occurs exactly 1 cycle after its read, so it never precedes the read of the same word.
- Valid/ready rules:
  - `out_valid`, once asserted, stays high and `out_data` stays stable until accepted.
  - `out_valid` does not depend combinationally on `out_ready`.

## Structure
- Shared package (`grid_pkg`): `COMPLEX`, `PRECISION`, `BRAM_PARALLELISM_BITS`, `BRAM_DEPTH_BITS`, the derived `BRAM_WIDTH`, and the FSM state encoding.
- Sub-module: `grid_skid_fifo`, a 2-entry FIFO with count output, carrying data plus a last bit.
- Top level: FSM, counter, credit logic and clear-write register.

## Test plan
Use `BRAM_DEPTH_BITS`=2 (4 words) and a 1-cycle-latency BRAM model preloaded with word k = {16{k+1}}.
- Pulse `start` with `out_ready`=1. Required: `out_data` = words 1,2,3,4 on cycles 2–5, `out_last` only on the 4th word, `done` at cycle 6, `busy` high cycles 1–5.
- With `CLEAR_ON_READ`=1, after the drain read all 4 words back. Required: all 0, and `bram_we` seen at addresses 0,16,32,48 in order.
- Hold `out_ready`=0 for 10 cycles after `start`, then release. Required: exactly 2 `bram_re` during the stall, `out_data` stable at word 1, and all 4 words then delivered in order.
- Toggle `out_ready` randomly for 200 cycles. Required: every word delivered exactly once and in order; `start` asserted mid-drain has no effect.
- Drive `rst`=0 at cycle 3 of a drain, then `start` again. Required: outputs 0 during reset, and a fresh drain from address 0 completes with `done`.
- With `CLEAR_ON_READ`=0, drain twice. Required: identical data both passes and `bram_we` never asserted.
